pc_seq_unit: RTL and testbench

//  Parametrised program-counter sequencer for the MIPS-style core; successor to the 6-bit PC.

---
 rtl/pc_seq_unit.sv | 106 ++++++++++
 tb/tb_pc_seq_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: branch/jump/call/ret with a return-address stack,
// stall, halt/resume, and a trap vector on stack overflow/underflow.
module pc_seq_unit #(
    parameter int                ADDR_W    = 6,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = '1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           halt,
    input  logic                           resume,
    input  logic                           branch,
    input  logic                           zero,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [ADDR_W-1:0]              imm_branch,
    input  logic [ADDR_W-1:0]              jump_addr,
    output logic [ADDR_W-1:0]              pc,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           trap_err
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]        state, state_n;
    logic [ADDR_W-1:0] pc_n, pc_inc;
    logic [CW-1:0]     cnt_n, top_idx;
    logic              trap_n, push_en;
    logic [ADDR_W-1:0] ras [2**AW];

    assign pc_inc  = pc + ADDR_W'(1);
    assign top_idx = ras_count - CW'(1);
    assign halted  = (state == S_HALT);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = ras_count;
        trap_n  = trap_err;
        push_en = 1'b0;
        if (!stall) begin
            if (state == S_HALT) begin
                if (resume) state_n = S_RUN;
            end else if (halt) begin
                state_n = S_HALT;
            end else begin
                // ret outranks call, so a same-cycle pair never pushes
                priority case (1'b1)
                    ret: begin
                        if (ras_count == '0) begin
                            pc_n   = TRAP_VEC;
                            cnt_n  = '0;
                            trap_n = 1'b1;
                        end else begin
                            pc_n  = ras[top_idx[AW-1:0]];
                            cnt_n = top_idx;
                        end
                    end
                    call: begin
                        if (ras_count == FULL) begin
                            pc_n   = TRAP_VEC;
                            cnt_n  = '0;
                            trap_n = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            pc_n    = jump_addr;
                            cnt_n   = ras_count + CW'(1);
                        end
                    end
                    jump:          pc_n = jump_addr;
                    branch & zero: pc_n = pc_inc + imm_branch;
                    default:       pc_n = pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            pc        <= RESET_VEC;
            ras_count <= '0;
            trap_err  <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ras_count <= cnt_n;
            trap_err  <= trap_n;
        end
    end

    // stack storage needs no reset; ras_count marks the valid entries
    always_ff @(posedge clk) begin
        if (push_en) ras[ras_count[AW-1:0]] <= pc_inc;
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: directed stimulus pushes expected
// state per cycle; a negedge monitor pops and compares.
module tb_pc_seq_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, halt, resume, branch, zero, jump, call, ret;
    logic [5:0] imm_branch, jump_addr;
    logic [5:0] pc;
    logic       halted;
    logic [2:0] ras_count;
    logic       trap_err;

    typedef struct {
        logic [5:0] pc;
        logic       h;
        logic [2:0] c;
        logic       t;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vecs = 0;
    int   errs = 0;

    pc_seq_unit #(
        .ADDR_W(6), .RAS_DEPTH(4), .RESET_VEC(6'd0), .TRAP_VEC(6'd63)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .resume(resume), .branch(branch), .zero(zero), .jump(jump),
        .call(call), .ret(ret), .imm_branch(imm_branch),
        .jump_addr(jump_addr), .pc(pc), .halted(halted),
        .ras_count(ras_count), .trap_err(trap_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            vecs++;
            if (pc !== e.pc || halted !== e.h ||
                ras_count !== e.c || trap_err !== e.t) begin
                errs++;
                $display("FAIL %s: got pc=%0d halted=%0b cnt=%0d trap=%0b, want pc=%0d halted=%0b cnt=%0d trap=%0b",
                         e.name, pc, halted, ras_count, trap_err,
                         e.pc, e.h, e.c, e.t);
            end
        end
    end

    task automatic clr();
        stall = 0; halt = 0; resume = 0; branch = 0; zero = 0;
        jump = 0; call = 0; ret = 0; imm_branch = '0; jump_addr = '0;
    endtask

    task automatic tick(input logic [5:0] p, input logic h,
                        input logic [2:0] c, input logic t,
                        input string n);
        exp_t x;
        @(posedge clk);
        x.pc = p; x.h = h; x.c = c; x.t = t; x.name = n;
        q.push_back(x);
        @(negedge clk);
        #1 clr();
    endtask

    task automatic go(input logic [5:0] a, input logic [2:0] c,
                      input logic t);
        jump = 1; jump_addr = a;
        tick(a, 0, c, t, "jump");
    endtask

    initial begin
        clr();
        reset = 1;
        #1;
        e.pc = 0; e.h = 0; e.c = 0; e.t = 0; e.name = "reset";
        q.push_back(e);
        @(negedge clk);
        #1 reset = 0;

        for (int i = 0; i < 70; i++)
            tick(6'((i + 1) % 64), 0, 0, 0, "freerun");

        go(10, 0, 0);
        branch = 1; zero = 1; imm_branch = 6'b111101;
        tick(8, 0, 0, 0, "br_back");
        go(10, 0, 0);
        branch = 1; zero = 0; imm_branch = 6'b111101;
        tick(11, 0, 0, 0, "br_not_taken");
        go(62, 0, 0);
        branch = 1; zero = 1; imm_branch = 6'd5;
        tick(4, 0, 0, 0, "br_wrap");

        go(5, 0, 0);
        call = 1; jump_addr = 20;
        tick(20, 0, 1, 0, "call");
        tick(21, 0, 1, 0, "seq21");
        tick(22, 0, 1, 0, "seq22");
        ret = 1;
        tick(6, 0, 0, 0, "ret");

        call = 1; jump_addr = 30; tick(30, 0, 1, 0, "call1");
        call = 1; jump_addr = 31; tick(31, 0, 2, 0, "call2");
        call = 1; jump_addr = 32; tick(32, 0, 3, 0, "call3");
        call = 1; jump_addr = 33; tick(33, 0, 4, 0, "call4");
        call = 1; jump_addr = 34; tick(63, 0, 0, 1, "overflow");
        ret = 1; tick(63, 0, 0, 1, "underflow");
        call = 1; jump_addr = 40; tick(40, 0, 1, 1, "call_from_63");
        ret = 1; tick(0, 0, 0, 1, "ret_wrap0");

        go(7, 0, 1);
        halt = 1; tick(7, 1, 0, 1, "halt");
        for (int i = 0; i < 10; i++) begin
            jump = 1; jump_addr = 50;
            tick(7, 1, 0, 1, "halted_hold");
        end
        resume = 1; tick(7, 0, 0, 1, "resume");
        tick(8, 0, 0, 1, "after_resume");
        stall = 1; jump = 1; jump_addr = 50;
        tick(8, 0, 0, 1, "stall_run");
        halt = 1; tick(8, 1, 0, 1, "halt2");
        stall = 1; resume = 1; tick(8, 1, 0, 1, "stall_resume");
        resume = 1; tick(8, 0, 0, 1, "resume2");
        tick(9, 0, 0, 1, "seq9");
        stall = 1; halt = 1; tick(9, 0, 0, 1, "stall_halt");

        call = 1; jump_addr = 20; tick(20, 0, 1, 1, "call_b");
        ret = 1; call = 1; jump_addr = 45;
        tick(10, 0, 0, 1, "ret_call");
        jump = 1; jump_addr = 12; branch = 1; zero = 1; imm_branch = 6'd9;
        tick(12, 0, 0, 1, "jump_over_br");

        call = 1; jump_addr = 1; tick(1, 0, 1, 1, "call_c");
        halt = 1; tick(1, 1, 1, 1, "halt3");
        #2 reset = 1;
        #1;
        e.pc = 0; e.h = 0; e.c = 0; e.t = 0; e.name = "async_reset";
        q.push_back(e);
        @(negedge clk);
        #1 reset = 0;
        tick(1, 0, 0, 0, "post_reset");

        @(negedge clk);
        vecs++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
